// File: rtl/data_mem_io_if.sv
// Core-side data memory bus: address, store data and strobes out, load data back.
interface data_mem_io_if;
  logic [31:0] Address_DataMem;
  logic [31:0] WriteData_DataMem;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData_DataMem;

  modport master (
    output Address_DataMem, WriteData_DataMem, MemWrite, MemRead,
    input  ReadData_DataMem
  );

  modport slave (
    input  Address_DataMem, WriteData_DataMem, MemWrite, MemRead,
    output ReadData_DataMem
  );
endinterface

// File: rtl/data_mem_io.sv
// Word-addressed data RAM plus memory-mapped GPIO and a compare/match timer.
module data_mem_io #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] IO_BASE   = 32'h100
) (
  input  logic            clk,
  input  logic            Reset,
  data_mem_io_if.slave    bus,
  output logic [31:0]     GPIO_out,
  output logic            Timer_irq,
  output logic            Access_error
);
  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] gpio, tcount, tcmp;
  logic        en, reload, flag, err;

  logic [31:0] addr, wdata;
  logic [AW-1:0] ram_idx;
  logic hit_ram, hit_gpio, hit_tcount, hit_tcmp, hit_tctrl, mapped;
  logic we, match;

  always_comb begin
    addr       = bus.Address_DataMem;
    wdata      = bus.WriteData_DataMem;
    we         = bus.MemWrite;
    ram_idx    = addr[AW-1:0];
    hit_ram    = addr < RAM_WORDS;
    hit_gpio   = addr == IO_BASE;
    hit_tcount = addr == IO_BASE + 32'd1;
    hit_tcmp   = addr == IO_BASE + 32'd2;
    hit_tctrl  = addr == IO_BASE + 32'd3;
    mapped     = hit_ram | hit_gpio | hit_tcount | hit_tcmp | hit_tctrl;
    match      = en && (tcmp != '0) && (tcount == tcmp);
  end

  always_comb begin
    bus.ReadData_DataMem = '0;
    if (bus.MemRead) begin
      if (hit_ram)         bus.ReadData_DataMem = ram[ram_idx];
      else if (hit_gpio)   bus.ReadData_DataMem = gpio;
      else if (hit_tcount) bus.ReadData_DataMem = tcount;
      else if (hit_tcmp)   bus.ReadData_DataMem = tcmp;
      else if (hit_tctrl)  bus.ReadData_DataMem = {29'd0, flag, reload, en};
    end
  end

  // RAM shares the reset process only so writes are blocked during Reset; its contents are never cleared.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      gpio   <= '0;
      tcount <= '0;
      tcmp   <= '0;
      en     <= 1'b0;
      reload <= 1'b0;
      flag   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (we && hit_ram)  ram[ram_idx] <= wdata;
      if (we && hit_gpio) gpio <= wdata;
      if (we && hit_tcmp) tcmp <= wdata;

      // Software writes override the hardware timer updates in the same cycle.
      if (we && hit_tcount) tcount <= '0;
      else if (match) begin
        if (reload) tcount <= '0;
      end else if (en) tcount <= tcount + 32'd1;

      if (we && hit_tctrl) begin
        en     <= wdata[0];
        reload <= wdata[1];
      end else if (match && !reload) begin
        en <= 1'b0;
      end

      if (match) flag <= 1'b1;
      else if (we && hit_tctrl && wdata[2]) flag <= 1'b0;

      if ((bus.MemRead || bus.MemWrite) && !mapped) err <= 1'b1;
    end
  end

  assign GPIO_out     = gpio;
  assign Timer_irq    = flag;
  assign Access_error = err;
endmodule

// File: tb/tb_data_mem_io.sv
// Directed and randomized checks of data_mem_io against a cycle-level behavioural model.
module tb_data_mem_io;
  localparam logic [31:0] IO = 32'h100;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] gpio_out;
  logic        timer_irq, access_error;

  data_mem_io_if bus ();

  data_mem_io #(.RAM_WORDS(256), .IO_BASE(IO)) dut (
    .clk(clk), .Reset(Reset), .bus(bus.slave),
    .GPIO_out(gpio_out), .Timer_irq(timer_irq), .Access_error(access_error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [31:0] m_ram [256];
  logic [31:0] m_gpio, m_tcount, m_tcmp;
  logic        m_en, m_reload, m_flag, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    return (a < 32'd256) || (a >= IO && a <= IO + 32'd3);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    if (!rd) return 32'h0;
    if (a < 32'd256) return m_ram[a[7:0]];
    if (a == IO) return m_gpio;
    if (a == IO + 32'd1) return m_tcount;
    if (a == IO + 32'd2) return m_tcmp;
    if (a == IO + 32'd3) return {29'd0, m_flag, m_reload, m_en};
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_gpio = '0; m_tcount = '0; m_tcmp = '0;
    m_en = 1'b0; m_reload = 1'b0; m_flag = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge: timer hardware first, then software writes overlay it.
  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
    bit hit;
    hit = m_en && (m_tcmp != 0) && (m_tcount == m_tcmp);
    if (hit) begin
      m_flag = 1'b1;
      if (m_reload) m_tcount = 0;
      else m_en = 1'b0;
    end else if (m_en) begin
      m_tcount = m_tcount + 1;
    end
    if (wr) begin
      if (a < 32'd256) m_ram[a[7:0]] = d;
      else if (a == IO) m_gpio = d;
      else if (a == IO + 32'd1) m_tcount = 0;
      else if (a == IO + 32'd2) m_tcmp = d;
      else if (a == IO + 32'd3) begin
        m_en = d[0];
        m_reload = d[1];
        if (d[2] && !hit) m_flag = 1'b0;
      end
    end
    if ((rd || wr) && !is_mapped(a)) m_err = 1'b1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                     output logic [31:0] r);
    bus.Address_DataMem = a;
    bus.WriteData_DataMem = d;
    bus.MemRead = rd;
    bus.MemWrite = wr;
    #1;
    r = bus.ReadData_DataMem;
    chk("read_data", r, model_read(a, rd));
    @(posedge clk);
    model_edge(a, d, rd, wr);
    #1;
    chk("gpio_out", gpio_out, m_gpio);
    chk("timer_irq", {31'd0, timer_irq}, {31'd0, m_flag});
    chk("access_error", {31'd0, access_error}, {31'd0, m_err});
    @(negedge clk);
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // Asynchronous reset between edges, with a GPIO write attempted while reset is held.
  task automatic do_reset();
    bus.Address_DataMem = IO;
    bus.WriteData_DataMem = 32'hFFFF;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b1;
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_gpio_now", gpio_out, 32'h0);
    chk("rst_irq_now", {31'd0, timer_irq}, 32'h0);
    chk("rst_err_now", {31'd0, access_error}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_write_ignored", gpio_out, 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] r, a, d;
    logic rd, wr;
    int unsigned sel;

    Reset = 1'b1;
    bus.Address_DataMem = '0;
    bus.WriteData_DataMem = '0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_irq", {31'd0, timer_irq}, 32'h0);
    chk("reset_err", {31'd0, access_error}, 32'h0);
    Reset = 1'b0;

    for (int unsigned i = 0; i < 16; i++) cyc(i, $urandom, 1'b0, 1'b1, r);
    cyc(32'd255, 32'h5555AAAA, 1'b0, 1'b1, r);
    cyc(32'd255, 32'h0, 1'b1, 1'b0, r);
    chk("ram_top_word", r, 32'h5555AAAA);

    // RAM path
    cyc(32'd5, 32'hDEADBEEF, 1'b0, 1'b1, r);
    cyc(32'd5, 32'h0, 1'b1, 1'b0, r);
    chk("ram_read", r, 32'hDEADBEEF);
    cyc(32'd5, 32'h0, 1'b0, 1'b0, r);
    chk("ram_noread", r, 32'h0);

    // Read/write collision
    cyc(32'd5, 32'd1, 1'b0, 1'b1, r);
    cyc(32'd5, 32'd2, 1'b1, 1'b1, r);
    chk("collide_old", r, 32'd1);
    cyc(32'd5, 32'd0, 1'b1, 1'b0, r);
    chk("collide_new", r, 32'd2);

    // One-shot timer
    cyc(IO + 2, 32'd3, 1'b0, 1'b1, r);
    cyc(IO + 3, 32'd1, 1'b0, 1'b1, r);
    for (int unsigned k = 0; k < 4; k++) begin
      cyc(IO + 1, 32'd0, 1'b1, 1'b0, r);
      chk("oneshot_count", r, k);
    end
    chk("oneshot_irq", {31'd0, timer_irq}, 32'd1);
    cyc(IO + 1, 32'd0, 1'b1, 1'b0, r);
    chk("oneshot_hold", r, 32'd3);
    cyc(IO + 3, 32'd0, 1'b1, 1'b0, r);
    chk("oneshot_tctrl", r, 32'h4);
    cyc(IO + 3, 32'h4, 1'b0, 1'b1, r);
    chk("oneshot_clear", {31'd0, timer_irq}, 32'd0);

    // Reload timer
    cyc(IO + 2, 32'd2, 1'b0, 1'b1, r);
    cyc(IO + 1, 32'd0, 1'b0, 1'b1, r);
    cyc(IO + 3, 32'h3, 1'b0, 1'b1, r);
    for (int unsigned k = 0; k < 5; k++) begin
      cyc(IO + 1, 32'd0, 1'b1, 1'b0, r);
      chk("reload_count", r, k % 3);
      if (k == 1) chk("reload_irq_pre", {31'd0, timer_irq}, 32'd0);
      if (k == 2) chk("reload_irq_set", {31'd0, timer_irq}, 32'd1);
    end
    cyc(IO + 3, 32'h7, 1'b0, 1'b1, r);
    chk("set_wins_w1c", {31'd0, timer_irq}, 32'd1);
    cyc(IO + 1, 32'd0, 1'b1, 1'b0, r);
    chk("reload_after_w1c", r, 32'd0);
    cyc(IO + 3, 32'h4, 1'b0, 1'b1, r);

    // GPIO and unmapped access
    cyc(IO, 32'hA5, 1'b0, 1'b1, r);
    chk("gpio_a5", gpio_out, 32'hA5);
    cyc(32'h200, 32'h0, 1'b1, 1'b0, r);
    chk("unmapped_read", r, 32'h0);
    chk("err_set", {31'd0, access_error}, 32'd1);
    cyc(32'd0, 32'h0, 1'b0, 1'b0, r);
    chk("err_sticky", {31'd0, access_error}, 32'd1);
    cyc(32'h10000100, 32'h0, 1'b1, 1'b0, r);
    chk("no_alias", r, 32'h0);

    // Mid-operation reset
    cyc(IO + 3, 32'h3, 1'b0, 1'b1, r);
    cyc(IO + 1, 32'h0, 1'b1, 1'b0, r);
    do_reset();
    cyc(IO + 1, 32'h0, 1'b1, 1'b0, r);
    chk("count_after_reset", r, 32'h0);
    cyc(IO + 1, 32'h0, 1'b1, 1'b0, r);
    chk("count_stopped", r, 32'h0);
    cyc(32'd5, 32'h0, 1'b1, 1'b0, r);
    chk("ram_survives_reset", r, 32'd2);

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(79) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(11);
        case (sel)
          0, 1, 2, 3: a = $urandom_range(15);
          4: a = IO;
          5: a = IO + 1;
          6, 7: a = IO + 2;
          8, 9: a = IO + 3;
          10: a = 32'd255;
          default: begin
            case ($urandom_range(3))
              0: a = IO + 4;
              1: a = 32'h200;
              2: a = 32'hFFFFFFFF;
              default: a = 32'h10000100;
            endcase
          end
        endcase
        if (a == IO + 2) d = $urandom_range(6);
        else if (a == IO + 3) d = $urandom_range(7);
        else d = $urandom;
        rd = 1'($urandom_range(1));
        wr = ($urandom_range(2) == 0);
        cyc(a, d, rd, wr, r);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and Reset.
REQ-002 The block SHALL have these ports:
  clk  input  1  rising-edge clock, shared with the core
  Reset  input  1  asynchronous, active-high reset
  Address_DataMem  input  32  word address from the core ALU result
  WriteData_DataMem  input  32  store data from the core
  MemWrite  input  1  store strobe, sampled on rising clk
  MemRead  input  1  load strobe; read path is combinational
  ReadData_DataMem  output  32  load data returned to the core in the same cycle
  GPIO_out  output  32  registered general-purpose output port
  Timer_irq  output  1  registered timer match flag
  Access_error  output  1  registered sticky flag for an unmapped access
REQ-003 The block SHALL use these parameters:
  RAM_WORDS, default 256, number of data RAM words (word-addressed)
  IO_BASE, default 32'h100, first I/O register word address

Function
REQ-004 Address map (word addresses):
  0 .. RAM_WORDS-1: RAM
  IO_BASE+0: GPIO, R/W
  IO_BASE+1: TCOUNT, R; any write loads 0
  IO_BASE+2: TCMP, R/W
  IO_BASE+3: TCTRL; bit0 EN R/W, bit1 RELOAD R/W, bit2 FLAG R/W1C, other bits read 0
  all other addresses: unmapped.
REQ-005 Reads SHALL be combinational. When MemRead=1, ReadData_DataMem is the current (pre-edge) value at Address_DataMem. When MemRead=0 or the address is unmapped, it is 32'h0.
REQ-006 Writes SHALL take effect on the rising clk edge where MemWrite=1. Writes to unmapped addresses have no effect on storage.
REQ-007 If MemRead=1 and MemWrite=1 together, the block SHALL perform the write and return the old data in that cycle.
REQ-008 Timer counting: while EN=1, TCOUNT SHALL increment by 1 every clk. It wraps from 32'hFFFFFFFF to 0 with no side effect.
REQ-009 Match event: when EN=1, TCMP!=0 and TCOUNT==TCMP at a clk edge, the block SHALL set FLAG.
  If RELOAD=1, TCOUNT loads 0 and EN stays 1.
  If RELOAD=0, TCOUNT holds and EN clears.
REQ-010 If TCMP=0, the timer SHALL never generate a match event.
REQ-011 A software write to TCOUNT SHALL take priority over the increment and the reload in the same cycle.
REQ-012 A software write to TCTRL SHALL take priority over the hardware EN clear in the same cycle.
REQ-013 When a match event and a write-1-to-clear of FLAG occur in the same cycle, FLAG SHALL end up 1 (set wins).
REQ-014 Timer_irq SHALL equal FLAG, driven directly from a register.
REQ-015 GPIO_out SHALL equal the GPIO register.
REQ-016 Access_error SHALL be set one edge after any cycle in which MemRead or MemWrite is 1 with an unmapped address. It SHALL stay set until Reset.
REQ-017 Only Address_DataMem bits [31:0] SHALL be decoded. There SHALL be no aliasing: the full 32-bit compare applies.

Reset
REQ-018 When Reset is asserted, the block SHALL immediately clear the following to 0, regardless of clk: GPIO, TCOUNT, TCMP, EN, RELOAD, FLAG, Access_error.
REQ-019 RAM contents SHALL NOT be reset. RAM reads before the first write return X in simulation.
REQ-020 While Reset=1, writes SHALL be ignored. ReadData_DataMem SHALL still follow REQ-005 using the reset register values.
REQ-021 If Reset is asserted while the timer is running, counting SHALL stop. Counting SHALL resume only after software sets EN again.

Verification
REQ-022 RAM path: write 32'hDEADBEEF to address 5, then read address 5 with MemRead=1 -> ReadData_DataMem=32'hDEADBEEF in the same cycle. With MemRead=0 -> 32'h0.
REQ-023 Read/write collision: address 5 holds 1; in one cycle drive MemRead=1, MemWrite=1 and data 2 -> ReadData_DataMem reads 1 that cycle and 2 the next cycle.
REQ-024 One-shot timer: TCMP=3, then TCTRL=1 -> TCOUNT goes 1, 2, 3.
  Edge after TCOUNT reads 3: FLAG=1, Timer_irq=1, EN=0, TCOUNT holds at 3.
  Write 32'h4 to TCTRL -> Timer_irq=0 on the next edge.
REQ-025 Reload timer: TCMP=2, TCTRL=32'h3 -> TCOUNT sequence 1, 2, 0, 1, 2, 0. FLAG sets at the first return to 0.
  Write 32'h7 to TCTRL on the cycle a match occurs -> FLAG remains 1.
REQ-026 Error and GPIO: write 32'hA5 to IO_BASE -> GPIO_out=32'hA5 after the edge. Read address 32'h200 -> ReadData_DataMem=0 and Access_error=1 after the next edge, and it stays 1.
REQ-027 Mid-operation reset: assert Reset between clk edges while the timer runs -> GPIO_out, Timer_irq and Access_error go to 0 immediately, and TCOUNT reads 0 after Reset is released.
